// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: button-driven operand capture for the ALU front panel.
// Optional HOLD_REPEAT_EN macro adds auto-repeat on a held inc/dec button.
module operand_entry_fsm #(
    parameter int WIDTH         = 4,
    parameter int NUM_OPS       = 2,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    localparam int SEL_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic                     in_clk,
    input  logic                     reset,
    input  logic                     inc_btn,
    input  logic                     dec_btn,
    input  logic                     save_btn,
    input  logic                     clear_btn,
    input  logic [SEL_W:0]           ops_needed,
    output logic [NUM_OPS*WIDTH-1:0] operands,
    output logic [SEL_W-1:0]         sel,
    output logic                     valid,
    output logic                     done,
    output logic                     btn_led
);
    typedef enum logic {S_ENTRY, S_DONE} state_t;

    localparam logic [SEL_W:0] NUM_OPS_W = NUM_OPS[SEL_W:0];

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ops_q [NUM_OPS];
    logic [WIDTH-1:0] ops_d [NUM_OPS];
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             done_q, done_d;
    logic             inc_q, dec_q, save_q, clear_q, led_q;
    logic             inc_p, dec_p, save_p, clear_p;
    logic [SEL_W:0]   n_eff;
    logic             last_slot;
    logic             step_up, step_dn;
    logic             rep_up, rep_dn;

    assign inc_p   = inc_btn & ~inc_q;
    assign dec_p   = dec_btn & ~dec_q;
    assign save_p  = save_btn & ~save_q;
    assign clear_p = clear_btn & ~clear_q;

    // Out-of-range requests fall back to the full slot count
    always_comb begin
        n_eff = ops_needed;
        if (ops_needed == '0 || ops_needed > NUM_OPS_W)
            n_eff = NUM_OPS_W;
    end

    assign last_slot = ({1'b0, sel_q} >= (n_eff - 1'b1));

`ifdef HOLD_REPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                             REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rpt_q, rpt_d;
    logic             alone;

    // cnt holds the number of held cycles since the press or last repeat
    always_comb begin
        cnt_d  = '0;
        rpt_d  = 1'b0;
        rep_up = 1'b0;
        rep_dn = 1'b0;
        alone  = ~(save_btn | clear_btn) & (inc_btn ^ dec_btn);
        if (state_q == S_ENTRY && alone) begin
            if (inc_p | dec_p) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != '0) begin
                if (cnt_q == (rpt_q ? PERIOD_C : DELAY_C)) begin
                    cnt_d  = CNT_W'(1);
                    rpt_d  = 1'b1;
                    rep_up = inc_btn;
                    rep_dn = dec_btn;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    rpt_d = rpt_q;
                end
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            cnt_q <= '0;
            rpt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rpt_q <= rpt_d;
        end
    end
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ops_d   = ops_q;
        done_d  = 1'b0;
        step_up = 1'b0;
        step_dn = 1'b0;
        if (clear_p) begin
            for (int i = 0; i < NUM_OPS; i++) ops_d[i] = '0;
            sel_d   = '0;
            state_d = S_ENTRY;
        end else if (save_p) begin
            unique case (state_q)
                S_ENTRY: begin
                    if (last_slot) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
                S_DONE: begin
                    sel_d   = '0;
                    state_d = S_ENTRY;
                end
                default: state_d = S_ENTRY;
            endcase
        end else if (state_q == S_ENTRY) begin
            step_up = (inc_p & ~dec_p) | rep_up;
            step_dn = (dec_p & ~inc_p) | rep_dn;
        end
        if (step_up) ops_d[sel_q] = ops_q[sel_q] + 1'b1;
        if (step_dn) ops_d[sel_q] = ops_q[sel_q] - 1'b1;
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_q <= S_ENTRY;
            sel_q   <= '0;
            done_q  <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            save_q  <= 1'b0;
            clear_q <= 1'b0;
            led_q   <= 1'b0;
            for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            inc_q   <= inc_btn;
            dec_q   <= dec_btn;
            save_q  <= save_btn;
            clear_q <= clear_btn;
            led_q   <= inc_btn | dec_btn | save_btn | clear_btn;
            ops_q   <= ops_d;
        end
    end

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_ops
        assign operands[g*WIDTH +: WIDTH] = ops_q[g];
    end

    assign sel     = sel_q;
    assign valid   = (state_q == S_DONE);
    assign done    = done_q;
    assign btn_led = led_q;
endmodule

// File: tb/tb_operand_entry_fsm.sv
// tb_operand_entry_fsm: scoreboard bench for operand_entry_fsm
// (WIDTH=4, NUM_OPS=2, repeat DELAY=4 PERIOD=2).
module tb_operand_entry_fsm;
    localparam int SEL_W = 1;

    logic       in_clk = 1'b0;
    logic       reset = 1'b1;
    logic       inc_btn = 1'b0, dec_btn = 1'b0;
    logic       save_btn = 1'b0, clear_btn = 1'b0;
    logic [1:0] ops_needed = 2'd2;
    logic [7:0] operands;
    logic [0:0] sel;
    logic       valid, done, btn_led;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [7:0] ops;
        logic [0:0] sel;
        logic       valid;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    operand_entry_fsm #(
        .WIDTH(4), .NUM_OPS(2), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
    ) dut (
        .in_clk(in_clk), .reset(reset),
        .inc_btn(inc_btn), .dec_btn(dec_btn),
        .save_btn(save_btn), .clear_btn(clear_btn),
        .ops_needed(ops_needed), .operands(operands),
        .sel(sel), .valid(valid), .done(done), .btn_led(btn_led)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic drive(input logic i, d, s, c);
        inc_btn = i; dec_btn = d; save_btn = s; clear_btn = c;
    endtask

    task automatic press(input logic i, d, s, c);
        drive(i, d, s, c);
        tick();
        drive(0, 0, 0, 0);
        tick();
    endtask

    task automatic push(input string n, input logic [7:0] o,
                        input logic [0:0] s, input logic v);
        exp_t x;
        x.name = n; x.ops = o; x.sel = s; x.valid = v;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({operands, sel, valid, done, btn_led} !== 12'h0) begin
            failures++;
            $display("FAIL reset: got ops=%h sel=%0d v=%b d=%b led=%b, want all 0",
                     operands, sel, valid, done, btn_led);
        end
    endtask

    task automatic test_inc_hold();
        logic [3:0] want;
        do_reset();
        push("inc3", 8'h03, 1'b0, 1'b0);
        repeat (3) press(1, 0, 0, 0);
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
`ifdef HOLD_REPEAT_EN
        want = 4'd12;
`else
        want = 4'd4;
`endif
        push("hold20", {4'h0, want}, 1'b0, 1'b0);
        drive(1, 0, 0, 0);
        tick();
        checks++;
        if (btn_led !== 1'b1) begin
            failures++;
            $display("FAIL led_on: got %b, want 1", btn_led);
        end
        repeat (19) tick();
        drive(0, 0, 0, 0);
        tick();
        checks++;
        if (btn_led !== 1'b0) begin
            failures++;
            $display("FAIL led_off: got %b, want 0", btn_led);
        end
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        push("inc16", 8'h00, 1'b0, 1'b0);
        push("dec_wrap", 8'h0F, 1'b0, 1'b0);
        repeat (16) press(1, 0, 0, 0);
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
        press(0, 1, 0, 0);
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
    endtask

    task automatic test_save_done();
        do_reset();
        push("save1", 8'h02, 1'b1, 1'b0);
        push("save2", 8'h52, 1'b1, 1'b1);
        push("inc_in_done", 8'h52, 1'b1, 1'b1);
        push("save_reentry", 8'h52, 1'b0, 1'b0);
        repeat (2) press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
        repeat (5) press(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse: got %b, want 1", done);
        end
        drive(0, 0, 0, 0);
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_width: got %b, want 0", done);
        end
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
        press(1, 0, 0, 0);
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
        press(0, 0, 1, 0);
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
    endtask

    task automatic test_ops_needed();
        logic [1:0] nlist [2];
        nlist[0] = 2'd0;
        nlist[1] = 2'd3;
        do_reset();
        ops_needed = 2'd1;
        push("n1_done", 8'h01, 1'b0, 1'b1);
        push("n1_back", 8'h01, 1'b0, 1'b0);
        push("inc_dec", 8'h01, 1'b0, 1'b0);
        press(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL n1_pulse: got %b, want 1", done);
        end
        drive(0, 0, 0, 0);
        tick();
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
        press(0, 0, 1, 0);
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
        press(1, 1, 0, 0);
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
        for (int k = 0; k < 2; k++) begin
            ops_needed = nlist[k];
            if (valid === 1'b1) press(0, 0, 1, 0);
            push($sformatf("n%0d_first", nlist[k]), 8'h01, 1'b1, 1'b0);
            push($sformatf("n%0d_second", nlist[k]), 8'h01, 1'b1, 1'b1);
            for (int s = 0; s < 2; s++) begin
                press(0, 0, 1, 0);
                e = sb.pop_front(); checks++;
                if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
                    failures++;
                    $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                             e.name, operands, sel, valid, e.ops, e.sel, e.valid);
                end
            end
        end
        ops_needed = 2'd2;
    endtask

    task automatic test_clear_and_reset();
        push("clear_in_done", 8'h00, 1'b0, 1'b0);
        push("reentry", 8'h13, 1'b1, 1'b0);
        drive(0, 0, 1, 1);
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL clear_no_done: got %b, want 0", done);
        end
        drive(0, 0, 0, 0);
        tick();
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
        repeat (3) press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
        reset = 1'b1;
        drive(1, 0, 0, 0);
        tick();
        checks++;
        if ({operands, sel, valid, done, btn_led} !== 12'h0) begin
            failures++;
            $display("FAIL mid_reset: got ops=%h sel=%0d v=%b d=%b led=%b, want all 0",
                     operands, sel, valid, done, btn_led);
        end
        drive(0, 0, 0, 0);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_repeat();
        logic [3:0] want;
`ifdef HOLD_REPEAT_EN
        want = 4'd4;
`else
        want = 4'd1;
`endif
        do_reset();
        push("hold10", {4'h0, want}, 1'b0, 1'b0);
        drive(1, 0, 0, 0);
        repeat (10) tick();
        drive(0, 0, 0, 0);
        repeat (3) tick();
        e = sb.pop_front(); checks++;
        if ({operands, sel, valid} !== {e.ops, e.sel, e.valid}) begin
            failures++;
            $display("FAIL %s: got ops=%h sel=%0d v=%b, want ops=%h sel=%0d v=%b",
                     e.name, operands, sel, valid, e.ops, e.sel, e.valid);
        end
    endtask

    initial begin
        test_reset();
        test_inc_hold();
        test_wrap();
        test_save_done();
        test_ops_needed();
        test_clear_and_reset();
        test_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
